// File: rtl/uart_alu_engine.sv
// uart_alu_engine
//   Byte-stream arithmetic engine sitting between a UART receiver and a UART
//   transmitter on the baud clock. A frame is one opcode byte followed by
//   NUM_OPERANDS operands of OPERAND_BYTES bytes each (MSB first). The engine
//   folds ADD/SUB/XOR/MAX over the operands and answers with a status byte
//   followed by the RESW-bit result, or with a single error status byte.
//
//   Ports:
//     hwclk        baud-domain clock
//     reset_n      asynchronous active-low reset
//     rx_byte      received byte, qualified by rx_valid
//     rx_valid     one-cycle strobe for rx_byte
//     tx_byte      byte to transmit, valid while tx_start is high
//     tx_start     one-cycle transmit request
//     tx_busy      transmitter busy; requests are only made while it is low
//     busy         high whenever the engine is not idle
//     frame_done   one-cycle pulse once the last response byte is handed off
//     last_status  status byte of the most recent response
//     drop_count   saturating count of rx bytes ignored while not receiving
module uart_alu_engine #(
    parameter int OPERAND_BYTES  = 2,
    parameter int NUM_OPERANDS   = 2,
    parameter int TIMEOUT_CYCLES = 96
) (
    input  logic       hwclk,
    input  logic       reset_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] last_status,
    output logic [7:0] drop_count
);

    localparam int OPW   = 8 * OPERAND_BYTES;
    localparam int RESW  = OPW + 8;
    localparam int TXW   = RESW + 8;
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0]       LAST_BYTE = 3'(OPERAND_BYTES - 1);
    localparam logic [3:0]       LAST_OPND = 4'(NUM_OPERANDS - 1);
    localparam logic [3:0]       RESP_LEN  = 4'(OPERAND_BYTES + 2);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       ST_OK     = 8'h00;
    localparam logic [7:0]       ST_BADOP  = 8'hE1;
    localparam logic [7:0]       ST_TMO    = 8'hE2;

    typedef enum logic [1:0] {IDLE, RECV, CALC, SEND} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_MAX} alu_op_t;

    state_t            state, state_next;
    alu_op_t           op_sel;
    logic [OPW-1:0]    op_reg;
    logic [RESW-1:0]   op_ext;
    logic [RESW-1:0]   acc;
    logic [2:0]        byte_idx;
    logic [3:0]        opnd_rx;     // operands fully received
    logic [3:0]        opnd_ap;     // operands folded into acc
    logic              op_pend;     // operand completed last cycle, fold pending
    logic              recv_done;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TXW-1:0]    tx_sh;
    logic [3:0]        tx_left;
    logic              tx_guard;    // masks tx_busy the cycle after tx_start
    logic [7:0]        status;

    logic opcode_ok, timeout_hit, final_update, issue, send_done, drop;

    assign op_ext = {8'h00, op_reg};
    assign busy   = (state != IDLE);

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next   = state;
        opcode_ok    = (rx_byte >= 8'h01) && (rx_byte <= 8'h04);
        timeout_hit  = 1'b0;
        final_update = 1'b0;
        issue        = 1'b0;
        send_done    = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) state_next = opcode_ok ? RECV : SEND;
            end
            RECV: begin
                timeout_hit  = (TIMEOUT_CYCLES != 0) && !recv_done && (tmo_cnt == TMO_LIMIT);
                final_update = op_pend && (opnd_ap == LAST_OPND);
                // Bytes arriving with a timeout or after the last operand are discarded.
                drop = rx_valid && (timeout_hit || recv_done);
                if (timeout_hit)       state_next = SEND;
                else if (final_update) state_next = CALC;
            end
            CALC: begin
                drop       = rx_valid;
                state_next = SEND;
            end
            SEND: begin
                drop      = rx_valid;
                issue     = (tx_left != 4'd0) && !tx_start && !tx_guard && !tx_busy;
                send_done = (tx_left == 4'd0) && !tx_start;
                if (send_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            op_sel      <= ALU_ADD;
            op_reg      <= '0;
            acc         <= '0;
            byte_idx    <= '0;
            opnd_rx     <= '0;
            opnd_ap     <= '0;
            op_pend     <= 1'b0;
            recv_done   <= 1'b0;
            tmo_cnt     <= '0;
            tx_sh       <= '0;
            tx_left     <= '0;
            tx_guard    <= 1'b0;
            status      <= '0;
            tx_byte     <= '0;
            tx_start    <= 1'b0;
            frame_done  <= 1'b0;
            last_status <= '0;
            drop_count  <= '0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            tx_guard   <= tx_start;
            op_pend    <= 1'b0;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        acc       <= '0;
                        op_reg    <= '0;
                        byte_idx  <= '0;
                        opnd_rx   <= '0;
                        opnd_ap   <= '0;
                        recv_done <= 1'b0;
                        tmo_cnt   <= '0;
                        case (rx_byte)
                            8'h01:   op_sel <= ALU_ADD;
                            8'h02:   op_sel <= ALU_SUB;
                            8'h03:   op_sel <= ALU_XOR;
                            8'h04:   op_sel <= ALU_MAX;
                            default: op_sel <= op_sel;
                        endcase
                        if (!opcode_ok) begin
                            status  <= ST_BADOP;
                            tx_sh   <= {ST_BADOP, {RESW{1'b0}}};
                            tx_left <= 4'd1;
                        end
                    end
                end
                RECV: begin
                    if (timeout_hit) begin
                        status  <= ST_TMO;
                        tx_sh   <= {ST_TMO, {RESW{1'b0}}};
                        tx_left <= 4'd1;
                    end else begin
                        if (rx_valid)                  tmo_cnt <= '0;
                        else if (TIMEOUT_CYCLES != 0)  tmo_cnt <= tmo_cnt + 1'b1;

                        if (rx_valid && !recv_done) begin
                            op_reg <= OPW'({op_reg, rx_byte});
                            if (byte_idx == LAST_BYTE) begin
                                byte_idx <= '0;
                                op_pend  <= 1'b1;
                                opnd_rx  <= opnd_rx + 4'd1;
                                if (opnd_rx == LAST_OPND) recv_done <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                            end
                        end

                        // Fold reads op_reg before any same-edge shift overwrites it.
                        if (op_pend) begin
                            opnd_ap <= opnd_ap + 4'd1;
                            if (opnd_ap == 4'd0) begin
                                acc <= op_ext;
                            end else begin
                                case (op_sel)
                                    ALU_ADD: acc <= acc + op_ext;
                                    ALU_SUB: acc <= acc - op_ext;
                                    ALU_XOR: acc <= acc ^ op_ext;
                                    ALU_MAX: acc <= (op_ext > acc) ? op_ext : acc;
                                    default: acc <= acc;
                                endcase
                            end
                        end
                    end
                end
                CALC: begin
                    status  <= ST_OK;
                    tx_sh   <= {ST_OK, acc};
                    tx_left <= RESP_LEN;
                end
                SEND: begin
                    if (issue) begin
                        tx_start <= 1'b1;
                        tx_byte  <= tx_sh[TXW-1 -: 8];
                        tx_sh    <= tx_sh << 8;
                        tx_left  <= tx_left - 4'd1;
                    end else if (send_done) begin
                        frame_done  <= 1'b1;
                        last_status <= status;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_engine.sv
module tb_uart_alu_engine;

    localparam int OB   = 2;
    localparam int NO   = 2;
    localparam int RB   = OB + 1;
    localparam int RESW = 8 * OB + 8;

    typedef logic [7:0] bq_t[$];

    logic       hwclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       frame_done;
    logic [7:0] last_status;
    logic [7:0] drop_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fd     = 0;
    int          busy_cnt = 0;
    logic [7:0]  exp_status = 8'h00;
    bq_t         exp_q;
    bq_t         got;

    uart_alu_engine #(
        .OPERAND_BYTES (OB),
        .NUM_OPERANDS  (NO),
        .TIMEOUT_CYCLES(96)
    ) dut (
        .hwclk      (hwclk),
        .reset_n    (reset_n),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .frame_done (frame_done),
        .last_status(last_status),
        .drop_count (drop_count)
    );

    always #5 hwclk = ~hwclk;

    // Transmitter model: busy for 10 cycles after accepting a byte.
    assign tx_busy = (busy_cnt != 0);
    always @(posedge hwclk) begin
        if (tx_start)           busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference: fold the operands with plain integer arithmetic modulo 2^RESW.
    task automatic model(input bq_t fr);
        longint unsigned mask = (64'd1 << RESW) - 1;
        longint unsigned acc  = 0;
        longint unsigned v;
        if (fr[0] < 8'h01 || fr[0] > 8'h04) begin
            exp_q.push_back(8'hE1);
            exp_status = 8'hE1;
            return;
        end
        for (int i = 0; i < NO; i++) begin
            v = 0;
            for (int j = 0; j < OB; j++) v = (v << 8) | longint'(fr[1 + i*OB + j]);
            if (i == 0) acc = v;
            else case (fr[0])
                8'h01: acc = (acc + v) & mask;
                8'h02: acc = (acc - v) & mask;
                8'h03: acc = acc ^ v;
                default: acc = (v > acc) ? v : acc;
            endcase
        end
        exp_q.push_back(8'h00);
        for (int k = RB - 1; k >= 0; k--) exp_q.push_back(8'((acc >> (8*k)) & 64'hFF));
        exp_status = 8'h00;
    endtask

    // Compare process: every transmit request and frame completion.
    always @(negedge hwclk) begin
        if (reset_n) begin
            if (tx_start) begin
                check("tx_busy_low_at_start", tx_busy, 0);
                check("busy_during_tx", busy, 1);
                check("tx_expected_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_byte", tx_byte, exp_q.pop_front());
                got.push_back(tx_byte);
            end
            if (frame_done) begin
                n_fd++;
                check("fd_queue_drained", exp_q.size(), 0);
                check("last_status", last_status, exp_status);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge hwclk); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge hwclk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge hwclk);
    endtask

    task automatic wait_done(input int unsigned fd0, input int budget);
        for (int i = 0; i < budget && n_fd == fd0; i++) @(negedge hwclk);
        check("frame_done_seen", n_fd != fd0, 1);
    endtask

    function automatic longint unsigned pack(input bq_t q);
        longint unsigned v = 0;
        foreach (q[i]) v = (v << 8) | longint'(q[i]);
        return v;
    endfunction

    task automatic finish_frame(input string name, input int unsigned fd0,
                                input int exp_len, input longint unsigned exp_val);
        wait_done(fd0, 600);
        repeat (2) @(negedge hwclk);
        check({name, "_len"}, got.size(), exp_len);
        check({name, "_bytes"}, pack(got), exp_val);
        check({name, "_fd_once"}, n_fd - fd0, 1);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic run_frame(input string name, input bq_t fr,
                             input int exp_len, input longint unsigned exp_val);
        int unsigned fd0 = n_fd;
        got.delete();
        model(fr);
        foreach (fr[i]) send_byte(fr[i]);
        finish_frame(name, fd0, exp_len, exp_val);
    endtask

    initial begin
        bq_t f;
        int unsigned fd0;

        repeat (3) @(negedge hwclk);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_last_status", last_status, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_tx_byte", tx_byte, 0);
        reset_n = 1'b1;

        f = '{8'h01, 8'h12, 8'h34, 8'h00, 8'h01};
        run_frame("add", f, 4, 32'h00001235);
        check("add_status", last_status, 8'h00);
        f = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame("add_ovf", f, 4, 32'h0001FFFE);
        f = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        run_frame("sub_wrap", f, 4, 32'h00FFFFFF);
        f = '{8'h04, 8'h00, 8'h05, 8'h01, 8'h00};
        run_frame("max", f, 4, 32'h00000100);
        f = '{8'h07};
        run_frame("bad_op", f, 1, 8'hE1);
        check("bad_op_status", last_status, 8'hE1);
        f = '{8'h03, 8'hF0, 8'hF0, 8'h0F, 8'h0F};
        run_frame("xor", f, 4, 32'h0000FFFF);

        // Timeout: partial frame then silence.
        fd0 = n_fd;
        got.delete();
        exp_q.push_back(8'hE2);
        exp_status = 8'hE2;
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (100) @(posedge hwclk);
        finish_frame("timeout", fd0, 1, 8'hE2);
        check("timeout_status", last_status, 8'hE2);
        f = '{8'h01, 8'h12, 8'h34, 8'h00, 8'h01};
        run_frame("add_after_tmo", f, 4, 32'h00001235);
        check("drops_before", drop_count, 0);

        // Bytes arriving during SEND are dropped and do not alter the response.
        fd0 = n_fd;
        got.delete();
        f = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model(f);
        foreach (f[i]) send_byte(f[i]);
        repeat (3) send_byte(8'hAA);
        finish_frame("drop", fd0, 4, 32'h0001FFFE);
        check("drop_count", drop_count, 3);

        // Reset in the middle of SEND.
        got.delete();
        f = '{8'h01, 8'h12, 8'h34, 8'h00, 8'h01};
        model(f);
        foreach (f[i]) send_byte(f[i]);
        for (int i = 0; i < 300 && got.size() == 0; i++) @(negedge hwclk);
        check("reset_reached_send", got.size() != 0, 1);
        @(posedge hwclk); #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_drop_count", drop_count, 0);
        check("rst_mid_last_status", last_status, 0);
        repeat (3) @(posedge hwclk);
        exp_q.delete();
        @(negedge hwclk);
        reset_n = 1'b1;
        f = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        run_frame("sub_after_rst", f, 4, 32'h00FFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

endmodule
